fetch_controller: RTL and testbench
===================================

# fetch_controller

Sequences the instruction memory: owns the program counter, issues word addresses to the 1024-word instruction ROM, and delivers fetched instructions to decode over a valid/ready handshake. It buffers up to two instructions so decode back-pressure never loses in-flight ROM data. It also handles branch/jump redirects from execute and stops fetching on a HALT instruction.

## Interface
- ADDR_WIDTH, 10, ROM word-address width; fetch_addr = pc[ADDR_WIDTH-1:0]
- RESET_PC, 32'd0, PC value loaded on reset
- HALT_OPCODE, 6'b111111, opcode in instr[31:26] that halts fetch
- clk  input  1  single clock, all state on rising edge
- reset  input  1  asynchronous, active-high
- fetch_addr  output  ADDR_WIDTH  ROM address, registered
- fetch_en  output  1  a read is issued this cycle
- rom_data  input  32  ROM output, valid exactly one cycle after fetch_en
- instr_out  output  32  instruction at FIFO head
- instr_pc  output  32  PC of instr_out
- instr_valid  output  1  FIFO non-empty and state not HALTED
- instr_ready  input  1  decode accepts head this cycle
- redirect_valid  input  1  one-cycle pulse: load new PC
- redirect_target  input  32  new PC, word address
- halted  output  1  high in HALTED

## Operation
- State: pc[31:0], 2-entry FIFO of {pc, instr}, inflight bit with inflight_pc, epoch bit (inflight_epoch captured at issue), FSM RUN / DRAIN / HALTED.
- Reset: pc=RESET_PC, FIFO empty, inflight=0, epoch=0, state RUN; outputs fetch_en=0, fetch_addr=0, instr_valid=0, instr_out=0, instr_pc=0, halted=0.
- Pop: instr_valid && instr_ready.
- Issue (RUN only, no redirect this cycle): when count − pop + inflight < 2. On issue: fetch_en=1, fetch_addr=pc[9:0], inflight_pc=pc, pc=pc+1 (32-bit, wraps at 2^32; ROM address wraps at 1024 naturally).
- Return: cycle after issue, if inflight_epoch==epoch, push {inflight_pc, rom_data}; else discard. Capacity rule guarantees push never overflows.
- Simultaneous push and pop: count unchanged; push into empty FIFO appears at head next cycle (no same-cycle bypass).
- Redirect (RUN or DRAIN): FIFO flushed (any pop this cycle still counts), epoch toggles so in-flight return is discarded, pc=redirect_target, no issue this cycle, state RUN. Redirect in HALTED ignored.
- HALT: when pushed instruction has instr[31:26]==HALT_OPCODE: state DRAIN, issuing stops, the next in-flight return (if any) is discarded. HALT instruction itself is delivered to decode.
- DRAIN → HALTED when FIFO empty and no pending redirect. HALTED: fetch_en=0, instr_valid=0, halted=1; exit only via reset.
- Reset asserted mid-operation clears everything immediately (asynchronous); in-flight ROM data in the cycle after release is ignored (inflight=0).

## Timing
- First fetch_en in first cycle after reset deasserts with fetch_addr=RESET_PC[9:0].
- Fetch-to-valid latency: issue cycle n, rom_data cycle n+1, instr_valid cycle n+2.
- Steady state with instr_ready=1: one instruction per cycle, PCs consecutive.
- Redirect in cycle n: fetch_en at target in cycle n+1; target instruction valid in n+3.
- instr_out/instr_pc stable while instr_valid && !instr_ready, except flush by redirect.
- halted rises the cycle after the FIFO empties in DRAIN.

## Test plan
- Reset release, ROM word k = 32'h1000_0000+k, instr_ready=1 → fetch_addr 0,1,2,… one per cycle; instr_valid from cycle 2 with instr_pc 0,1,2, instr_out 32'h1000_0000, …_0001, …_0002.
- instr_ready low for 5 cycles from steady state → FIFO fills to 2, fetch_en stops, no instruction lost or duplicated; on release PCs resume contiguous.
- redirect_valid with target 32'h40 while FIFO holds 2 and one in flight → FIFO flushed, stale return dropped, next fetch_addr=10'h40, next delivered instr_pc=32'h40.
- pc=32'h3FF with ROM word 0 = 32'hDEAD_BEEF → fetch_addr wraps 10'h3FF→10'h000, instr_pc 32'h400 carries 32'hDEAD_BEEF.
- HALT (32'hFC00_0000) at address 5 → instructions 0–5 delivered, address 6 return discarded, halted=1 after HALT popped; redirect_valid afterward ignored; reset returns to RUN at RESET_PC.
- reset asserted asynchronously between clock edges mid-stream → all outputs zero immediately; after release restart at RESET_PC with no stale instruction delivered.

Source files
------------

// File: rtl/fetch_controller_if.sv
// Fetch-side bus bundle: ROM read port, decode delivery handshake, redirect input, halt status.
// master = fetch_controller; slave = ROM / decode / execute environment.
// Ports: fetch_addr/fetch_en/rom_data (ROM), instr_* (decode), redirect_* (execute), halted.
interface fetch_controller_if #(
    parameter int ADDR_WIDTH = 10
);
    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic                  fetch_en;
    logic [31:0]           rom_data;
    logic [31:0]           instr_out;
    logic [31:0]           instr_pc;
    logic                  instr_valid;
    logic                  instr_ready;
    logic                  redirect_valid;
    logic [31:0]           redirect_target;
    logic                  halted;

    modport master (
        output fetch_addr,
        output fetch_en,
        input  rom_data,
        output instr_out,
        output instr_pc,
        output instr_valid,
        input  instr_ready,
        input  redirect_valid,
        input  redirect_target,
        output halted
    );

    modport slave (
        input  fetch_addr,
        input  fetch_en,
        output rom_data,
        input  instr_out,
        input  instr_pc,
        input  instr_valid,
        output instr_ready,
        output redirect_valid,
        output redirect_target,
        input  halted
    );
endinterface

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, reads the instruction ROM, buffers up to two words for decode.
// Latency: issue in cycle n, ROM data in n+1, instruction valid at decode in n+2; one per cycle steady state.
// Backpressure: issue is throttled so FIFO entries plus the in-flight read never exceed two; nothing is dropped.
//
// Ports: clk, reset (async, active-high); bus (master modport of fetch_controller_if):
//   fetch_addr/fetch_en  -> ROM read request, rom_data <- ROM word one cycle later
//   instr_out/instr_pc/instr_valid -> decode, instr_ready <- decode
//   redirect_valid/redirect_target <- execute (branch/jump), halted -> status
module fetch_controller #(
    parameter int          ADDR_WIDTH  = 10,
    parameter logic [31:0] RESET_PC    = 32'd0,
    parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
    input  logic               clk,
    input  logic               reset,
    fetch_controller_if.master bus
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    // Architectural state
    state_t      state;
    logic [31:0] pc;
    entry_t      fifo_q [2];        // fifo_q[0] is always the head
    logic [1:0]  count;
    logic        inflight;          // a ROM word is returning this cycle
    logic [31:0] inflight_pc;
    logic        inflight_epoch;
    logic        epoch;
    logic        halted_q;

    // Per-cycle decisions
    logic        pop;
    logic        redirect;
    logic        ret_match;
    logic        push;
    logic        push_is_halt;
    logic        issue;
    logic [1:0]  fill;              // entries left after this cycle's pop
    logic [1:0]  occupancy;         // entries committed after this cycle (fill + return)
    entry_t      push_entry;

    always_comb begin
        pop       = 1'b0;
        redirect  = 1'b0;
        ret_match = 1'b0;
        push      = 1'b0;
        issue     = 1'b0;
        fill      = 2'd0;
        occupancy = 2'd0;

        pop       = (count != 2'd0) && (state != ST_HALTED) && bus.instr_ready;
        // HALTED ignores execute entirely; only reset leaves it.
        redirect  = bus.redirect_valid && (state != ST_HALTED);
        // A return issued under an older epoch belongs to the wrong path.
        ret_match = inflight && (inflight_epoch == epoch);
        // Once HALT has been captured, every later return is past the end of the program.
        push      = ret_match && (state == ST_RUN) && !redirect;

        fill      = count - {1'b0, pop};
        occupancy = fill + {1'b0, inflight};
        // Reserve room for the word being issued now; the in-flight return is counted
        // even if it will be discarded, which keeps the capacity check simple.
        issue     = !reset && (state == ST_RUN) && !redirect && (occupancy < 2'd2);

        push_entry.pc    = inflight_pc;
        push_entry.instr = bus.rom_data;
        push_is_halt     = push && (bus.rom_data[31:26] == HALT_OPCODE);
    end

    // The ROM address comes straight from the PC register; it is forced to zero on
    // idle cycles so the address bus only moves when a read is actually issued.
    assign bus.fetch_en    = issue;
    assign bus.fetch_addr  = issue ? pc[ADDR_WIDTH-1:0] : '0;
    assign bus.instr_out   = fifo_q[0].instr;
    assign bus.instr_pc    = fifo_q[0].pc;
    assign bus.instr_valid = (count != 2'd0) && (state != ST_HALTED);
    assign bus.halted      = halted_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_RUN;
            pc             <= RESET_PC;
            count          <= 2'd0;
            inflight       <= 1'b0;
            inflight_pc    <= 32'd0;
            inflight_epoch <= 1'b0;
            epoch          <= 1'b0;
            halted_q       <= 1'b0;
            fifo_q[0]      <= '0;
            fifo_q[1]      <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc    <= pc;
                inflight_epoch <= epoch;
                pc             <= pc + 32'd1;
            end

            if (redirect) begin
                // Flush: the pop this cycle (if any) already happened at decode,
                // everything still buffered or returning is on the wrong path.
                count <= 2'd0;
                epoch <= ~epoch;
                pc    <= bus.redirect_target;
                state <= ST_RUN;
            end else begin
                count <= fill + {1'b0, push};

                if (pop) begin
                    fifo_q[0] <= fifo_q[1];
                end
                // Written after the shift so a push into the slot vacated by the pop wins.
                if (push) begin
                    fifo_q[fill[0]] <= push_entry;
                end

                case (state)
                    ST_RUN: begin
                        if (push_is_halt) begin
                            state <= ST_DRAIN;
                        end
                    end
                    ST_DRAIN: begin
                        if (count == 2'd0) begin
                            state    <= ST_HALTED;
                            halted_q <= 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_HALTED;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
module tb_fetch_controller;

    localparam int AW = 10;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    fetch_controller_if #(.ADDR_WIDTH(AW)) bus ();

    fetch_controller #(
        .ADDR_WIDTH  (AW),
        .RESET_PC    (32'd0),
        .HALT_OPCODE (6'b111111)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Synchronous instruction ROM: word is available the cycle after fetch_en.
    logic [31:0] rom [1024];
    always @(posedge clk) begin
        if (bus.fetch_en) begin
            bus.rom_data <= rom[bus.fetch_addr];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Apply inputs at the falling edge and let combinational outputs settle.
    task automatic cyc(input logic rdy, input logic rv, input logic [31:0] tgt, input logic rst_val);
        @(negedge clk);
        reset               = rst_val;
        bus.instr_ready     = rdy;
        bus.redirect_valid  = rv;
        bus.redirect_target = tgt;
        #1;
    endtask

    task automatic expect_outs(input string tag, input logic en, input logic [9:0] addr,
                               input logic vld, input logic [31:0] pc, input logic [31:0] out,
                               input logic hlt);
        chk({tag, " fetch_en"}, 32'(bus.fetch_en), 32'(en));
        if (en) chk({tag, " fetch_addr"}, 32'(bus.fetch_addr), 32'(addr));
        chk({tag, " instr_valid"}, 32'(bus.instr_valid), 32'(vld));
        if (vld) begin
            chk({tag, " instr_pc"}, bus.instr_pc, pc);
            chk({tag, " instr_out"}, bus.instr_out, out);
        end
        chk({tag, " halted"}, 32'(bus.halted), 32'(hlt));
    endtask

    task automatic expect_all_zero(input string tag);
        chk({tag, " fetch_en"}, 32'(bus.fetch_en), 32'd0);
        chk({tag, " fetch_addr"}, 32'(bus.fetch_addr), 32'd0);
        chk({tag, " instr_valid"}, 32'(bus.instr_valid), 32'd0);
        chk({tag, " instr_out"}, bus.instr_out, 32'd0);
        chk({tag, " instr_pc"}, bus.instr_pc, 32'd0);
        chk({tag, " halted"}, 32'(bus.halted), 32'd0);
    endtask

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] tgt;
        logic        en;
        logic [9:0]  addr;
        logic        vld;
        logic [31:0] pc;
    } vec_t;

    function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] tgt,
                                input logic en, input logic [9:0] addr,
                                input logic vld, input logic [31:0] pc);
        vec_t v;
        v.rdy  = rdy;
        v.rv   = rv;
        v.tgt  = tgt;
        v.en   = en;
        v.addr = addr;
        v.vld  = vld;
        v.pc   = pc;
        return v;
    endfunction

    vec_t vt [18];

    initial begin
        logic [31:0] epc;
        logic [31:0] eout;

        for (int k = 0; k < 1024; k++) rom[k] = 32'h1000_0000 + k;
        bus.instr_ready     = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = 32'd0;

        // Stream from reset, 5-cycle stall, then redirect to 0x40 with a word returning.
        //        rdy   rv    tgt     en    addr    vld   pc
        vt[0]  = mk(1'b1, 1'b0, 32'h0,  1'b1, 10'h0,  1'b0, 32'h0);
        vt[1]  = mk(1'b1, 1'b0, 32'h0,  1'b1, 10'h1,  1'b0, 32'h0);
        vt[2]  = mk(1'b1, 1'b0, 32'h0,  1'b1, 10'h2,  1'b1, 32'h0);
        vt[3]  = mk(1'b1, 1'b0, 32'h0,  1'b1, 10'h3,  1'b1, 32'h1);
        vt[4]  = mk(1'b0, 1'b0, 32'h0,  1'b0, 10'h0,  1'b1, 32'h2);
        vt[5]  = mk(1'b0, 1'b0, 32'h0,  1'b0, 10'h0,  1'b1, 32'h2);
        vt[6]  = mk(1'b0, 1'b0, 32'h0,  1'b0, 10'h0,  1'b1, 32'h2);
        vt[7]  = mk(1'b0, 1'b0, 32'h0,  1'b0, 10'h0,  1'b1, 32'h2);
        vt[8]  = mk(1'b0, 1'b0, 32'h0,  1'b0, 10'h0,  1'b1, 32'h2);
        vt[9]  = mk(1'b1, 1'b0, 32'h0,  1'b1, 10'h4,  1'b1, 32'h2);
        vt[10] = mk(1'b1, 1'b0, 32'h0,  1'b1, 10'h5,  1'b1, 32'h3);
        vt[11] = mk(1'b1, 1'b0, 32'h0,  1'b1, 10'h6,  1'b1, 32'h4);
        vt[12] = mk(1'b1, 1'b0, 32'h0,  1'b1, 10'h7,  1'b1, 32'h5);
        vt[13] = mk(1'b0, 1'b1, 32'h40, 1'b0, 10'h0,  1'b1, 32'h6);
        vt[14] = mk(1'b1, 1'b0, 32'h0,  1'b1, 10'h40, 1'b0, 32'h0);
        vt[15] = mk(1'b1, 1'b0, 32'h0,  1'b1, 10'h41, 1'b0, 32'h0);
        vt[16] = mk(1'b1, 1'b0, 32'h0,  1'b1, 10'h42, 1'b1, 32'h40);
        vt[17] = mk(1'b1, 1'b0, 32'h0,  1'b1, 10'h43, 1'b1, 32'h41);

        // Reset state while reset is held.
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        expect_all_zero("reset");

        for (int i = 0; i < 18; i++) begin
            cyc(vt[i].rdy, vt[i].rv, vt[i].tgt, 1'b0);
            expect_outs($sformatf("vec%0d", i), vt[i].en, vt[i].addr, vt[i].vld,
                        vt[i].pc, 32'h1000_0000 + vt[i].pc, 1'b0);
        end

        // ROM address wrap: PC 0x3FF then 0x400 reads word 0.
        rom[0] = 32'hDEAD_BEEF;
        cyc(1'b1, 1'b1, 32'h3FF, 1'b0);
        chk("wrap redirect fetch_en", 32'(bus.fetch_en), 32'd0);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        expect_outs("wrap0", 1'b1, 10'h3FF, 1'b0, 32'h0, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        expect_outs("wrap1", 1'b1, 10'h000, 1'b0, 32'h0, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        expect_outs("wrap2", 1'b1, 10'h001, 1'b1, 32'h3FF, 32'h1000_03FF, 1'b0);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        expect_outs("wrap3", 1'b1, 10'h002, 1'b1, 32'h400, 32'hDEAD_BEEF, 1'b0);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        expect_outs("wrap4", 1'b1, 10'h003, 1'b1, 32'h401, 32'h1000_0001, 1'b0);

        // HALT at address 5: 0..5 delivered, 6 fetched but dropped, then HALTED.
        rom[0] = 32'h1000_0000;
        rom[5] = 32'hFC00_0000;
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        for (int k = 0; k < 10; k++) begin
            cyc(1'b1, 1'b0, 32'h0, 1'b0);
            epc  = 32'(k) - 32'd2;
            eout = (epc == 32'd5) ? 32'hFC00_0000 : 32'h1000_0000 + epc;
            expect_outs($sformatf("halt%0d", k), (k <= 6), 10'(k),
                        (k >= 2 && k <= 7), epc, eout, (k >= 9));
        end
        cyc(1'b1, 1'b1, 32'h10, 1'b0);
        expect_outs("halt redirect", 1'b0, 10'h0, 1'b0, 32'h0, 32'h0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 1'b0, 32'h0, 1'b0);
            expect_outs($sformatf("halt hold%0d", k), 1'b0, 10'h0, 1'b0, 32'h0, 32'h0, 1'b1);
        end

        // Reset out of HALTED, asserted between edges.
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        expect_all_zero("halt reset");
        rom[5] = 32'h1000_0005;
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            cyc(1'b1, 1'b0, 32'h0, 1'b0);
            epc = 32'(k) - 32'd2;
            expect_outs($sformatf("restart%0d", k), 1'b1, 10'(k), (k >= 2), epc,
                        32'h1000_0000 + epc, 1'b0);
        end

        // Asynchronous reset mid-stream; rom_data still holds word 5 afterwards.
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        expect_all_zero("async reset");
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        expect_all_zero("async reset held");
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, 1'b0, 32'h0, 1'b0);
            epc = 32'(k) - 32'd2;
            expect_outs($sformatf("post reset%0d", k), 1'b1, 10'(k), (k >= 2), epc,
                        32'h1000_0000 + epc, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
